// File: rtl/vend_pkg.sv
// Shared types for the vending coin scheduler: coin codes and issue FSM states.
package vend_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    NICKEL = 2'b01,
    DIME   = 2'b10,
    BAD    = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } sched_state_t;

  function automatic logic coin_ok(input coin_t c);
    return (c == NICKEL) || (c == DIME);
  endfunction

endpackage

// File: rtl/vend_coin_fifo.sv
// Small coin FIFO; DEPTH is a power of two so the pointers wrap on their own.
module vend_coin_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  coin_t                    din,
  input  logic                     pop,
  output coin_t                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  coin_t           mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic            wr, rd;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      case ({wr, rd})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

endmodule

// File: rtl/vend_coin_sched.sv
// Round-robin coin arbiter + FIFO + one-coin-at-a-time issue FSM feeding a Mealy vending FSM.
// Optional VEND_COIN_STATS_EN adds nickel/dime/reject counters.
module vend_coin_sched
  import vend_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [1:0]               a_coin,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [1:0]               b_coin,
  output logic                     b_ready,
  output logic                     n,
  output logic                     d,
  input  logic                     q,
  output logic [CNT_W-1:0]         vend_count,
  output logic                     reject,
  output logic [$clog2(DEPTH):0]   level
`ifdef VEND_COIN_STATS_EN
  ,
  output logic [CNT_W-1:0]         nickel_count,
  output logic [CNT_W-1:0]         dime_count,
  output logic [CNT_W-1:0]         reject_count
`endif
);

  sched_state_t state, state_nxt;
  logic  ptr_b;
  logic  grant_a, grant_b, accept, cin_ok, push, pop, full, empty;
  logic  n_nxt, d_nxt;
  coin_t cin, head;

  // Pointer only matters on contention; a lone requester always wins.
  assign grant_a = a_valid && (!b_valid || !ptr_b);
  assign grant_b = b_valid && (!a_valid || ptr_b);
  assign a_ready = grant_a && !full && !reset;
  assign b_ready = grant_b && !full && !reset;
  assign accept  = a_ready || b_ready;
  assign cin     = a_ready ? coin_t'(a_coin) : coin_t'(b_coin);
  assign cin_ok  = coin_ok(cin);
  assign push    = accept && cin_ok;

  vend_coin_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (cin),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_b  <= 1'b0;
      reject <= 1'b0;
    end else begin
      reject <= accept && !cin_ok;
      if (accept && cin_ok && a_valid && b_valid) ptr_b <= !ptr_b;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    n_nxt     = 1'b0;
    d_nxt     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        n_nxt     = (head == NICKEL);
        d_nxt     = (head == DIME);
        state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // q is the FSM's Mealy response to the strobe, so it is sampled at the edge closing ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      n          <= 1'b0;
      d          <= 1'b0;
      vend_count <= '0;
    end else begin
      state <= state_nxt;
      n     <= n_nxt;
      d     <= d_nxt;
      if (state == ISSUE && q) vend_count <= vend_count + CNT_W'(1);
    end
  end

`ifdef VEND_COIN_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nickel_count <= '0;
      dime_count   <= '0;
      reject_count <= '0;
    end else begin
      if (state == ISSUE && n) nickel_count <= nickel_count + CNT_W'(1);
      if (state == ISSUE && d) dime_count   <= dime_count + CNT_W'(1);
      if (accept && !cin_ok)   reject_count <= reject_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vend_coin_sched.sv
// Directed bench for vend_coin_sched with a 5/10/15-cent Mealy vending FSM hooked to n/d/q.
module tb_vend_coin_sched;
  import vend_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             a_valid = 1'b0, b_valid = 1'b0;
  logic [1:0]       a_coin = 2'b00, b_coin = 2'b00;
  logic             a_ready, b_ready, n, d, q, reject;
  logic [CNT_W-1:0] vend_count;
  logic [2:0]       level;
`ifdef VEND_COIN_STATS_EN
  logic [CNT_W-1:0] nickel_count, dime_count, reject_count;
`endif

  int tests = 0, failed = 0;
  logic [1:0] vst;          // vending FSM credit in nickels: 0, 1, 2
  logic overlap = 1'b0;

  vend_coin_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_coin(a_coin), .a_ready(a_ready),
    .b_valid(b_valid), .b_coin(b_coin), .b_ready(b_ready),
    .n(n), .d(d), .q(q),
    .vend_count(vend_count), .reject(reject), .level(level)
`ifdef VEND_COIN_STATS_EN
    , .nickel_count(nickel_count), .dime_count(dime_count), .reject_count(reject_count)
`endif
  );

  always #5 clk = ~clk;

  // Mealy vending FSM: dispenses once 15 cents is reached.
  assign q = ((vst == 2'd2) && (n || d)) || ((vst == 2'd1) && d);
  always @(posedge clk or posedge reset) begin
    if (reset)  vst <= 2'd0;
    else if (q) vst <= 2'd0;
    else if (n) vst <= vst + 2'd1;
    else if (d) vst <= vst + 2'd2;
  end

  always @(negedge clk) if (n && d) overlap <= 1'b1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int   pulses[$];
    int   dp, dq, np;
    logic seen;
    logic [1:0] seq [6];

    // Reset state
    reset = 1'b1; a_valid = 1'b1; a_coin = NICKEL;
    step(); step(); #1;
    chk("rst_n", n, 0);  chk("rst_d", d, 0);
    chk("rst_vend", vend_count, 0); chk("rst_reject", reject, 0);
    chk("rst_level", level, 0);     chk("rst_a_ready", a_ready, 0);
    a_valid = 1'b0; reset = 1'b0;
    step();

    // Three nickels from A: strobes at cycles 2, 5, 8; one vend
    for (int i = 0; i < 15; i++) begin
      a_valid = (i < 3); a_coin = NICKEL;
      #1;
      if (i < 3) chk("t1_a_ready", a_ready, 1);
      if (n) pulses.push_back(i);
      step();
    end
    chk("t1_pulse_cnt", pulses.size(), 3);
    if (pulses.size() == 3) begin
      chk("t1_pulse0", pulses[0], 2);
      chk("t1_pulse1", pulses[1], 5);
      chk("t1_pulse2", pulses[2], 8);
    end
    chk("t1_vend", vend_count, 1);
    chk("t1_level", level, 0);

    // Contention: A/B alternate, FIFO fills, readies drop until the next pop
    for (int i = 0; i < 9; i++) begin
      a_valid = 1'b1; a_coin = DIME; b_valid = 1'b1; b_coin = DIME;
      #1;
      if (i < 6) begin
        chk("t2_a_ready", a_ready, (i % 2 == 0));
        chk("t2_b_ready", b_ready, (i % 2 == 1));
      end else if (i < 8) begin
        chk("t2_full_level", level, 4);
        chk("t2_full_a_ready", a_ready, 0);
        chk("t2_full_b_ready", b_ready, 0);
      end else begin
        chk("t2_after_pop_level", level, 3);
        chk("t2_after_pop_a_ready", a_ready, 1);
        a_valid = 1'b0; b_valid = 1'b0;
      end
      step();
    end
    repeat (14) step();
    #1;
    chk("t2_drain_level", level, 0);
    chk("t2_vend", vend_count, 4);

    // Invalid codes: handshaken, reject next cycle, no push, pointer held
    b_valid = 1'b1; b_coin = 2'b11; #1;
    chk("t3_b_ready", b_ready, 1); chk("t3_a_ready", a_ready, 0);
    step(); b_valid = 1'b0; #1;
    chk("t3_reject", reject, 1); chk("t3_level", level, 0);
    step(); #1;
    chk("t3_reject_clr", reject, 0);
    a_valid = 1'b1; a_coin = BAD; b_valid = 1'b1; b_coin = NICKEL; #1;
    chk("t3_bad_a_ready", a_ready, 1); chk("t3_bad_b_ready", b_ready, 0);
    step(); #1;
    chk("t3_reject2", reject, 1);
    chk("t3_ptr_a_ready", a_ready, 1); chk("t3_ptr_b_ready", b_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin step(); #1; if (n || d) seen = 1'b1; end
    chk("t3_no_strobe", seen, 0);
    chk("t3_level_end", level, 0);

    // DIME, DIME, NICKEL: second dime vends exactly once
    dp = 0; dq = 0; np = 0;
    for (int i = 0; i < 14; i++) begin
      a_valid = (i < 3); a_coin = (i < 2) ? DIME : NICKEL;
      #1;
      if (i < 3) chk("t4_a_ready", a_ready, 1);
      if (d) begin dp++; if (q) dq++; end
      if (n) np++;
      step();
    end
    chk("t4_d_pulses", dp, 2); chk("t4_d_with_q", dq, 1);
    chk("t4_n_pulses", np, 1); chk("t4_vend", vend_count, 5);

    // Reset during ISSUE with three coins queued
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; a_coin = NICKEL; step();
    end
    a_valid = 1'b0; #1;
    chk("t5_issue_n", n, 1); chk("t5_level3", level, 3); chk("t5_q_pending", q, 1);
    reset = 1'b1; #1;
    chk("t5_async_n", n, 0); chk("t5_async_level", level, 0);
    chk("t5_async_vend", vend_count, 0);
    step(); step(); reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin step(); #1; if (n || d) seen = 1'b1; end
    chk("t5_no_strobe", seen, 0);
    chk("t5_vend_held", vend_count, 0);
    a_valid = 1'b1; a_coin = NICKEL; #1;
    chk("t5_new_ready", a_ready, 1);
    step(); a_valid = 1'b0; step(); #1;
    chk("t5_new_strobe", n, 1);

    // Mixed stream after fresh reset: 2 nickels, 3 dimes, 1 bad
    reset = 1'b1; step(); reset = 1'b0; step();
    seq[0] = NICKEL; seq[1] = DIME; seq[2] = NICKEL;
    seq[3] = DIME;   seq[4] = DIME; seq[5] = BAD;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_coin = seq[i]; #1;
      chk("t6_a_ready", a_ready, 1);
      step();
    end
    a_valid = 1'b0;
    repeat (20) step();
    #1;
    chk("t6_vend", vend_count, 2);
    chk("t6_level", level, 0);
`ifdef VEND_COIN_STATS_EN
    chk("t6_nickel_count", nickel_count, 2);
    chk("t6_dime_count", dime_count, 3);
    chk("t6_reject_count", reject_count, 1);
`endif

    chk("no_nd_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
